fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Forwarding and hazard control for the 5-stage pipelined MIPS datapath.
- Internally shadows the register-destination info of the instructions in EX, MEM and WB.
- Drives the 2-bit select codes of the two EX-stage operand forwarding muxes.
- Detects load-use hazards and generates the stall/bubble controls for PC, IF/ID and ID/EX.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  REG_W  rs field of the instruction in ID.
- id_rt  input  REG_W  rt field of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt (R-type, beq, sw).
- id_dest  input  REG_W  destination register of the ID instruction, already resolved by RegDst.
- id_reg_write  input  1  ID instruction writes the register file.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  branch taken: squash the instruction in ID.
- forward_a  output  2  operand-A mux select.
- forward_b  output  2  operand-B mux select.
- stall  output  1  load-use hazard this cycle.
- pc_write  output  1  PC update enable (equals ~stall).
- ifid_write  output  1  IF/ID update enable (equals ~stall).
- idex_bubble  output  1  ID/EX must load a NOP.
- stall_count  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Internal shadow stages, all cleared on reset:
  - EX: v, rs, rt, dest, rw, mr.
  - MEM: v, dest, rw.
  - WB: v, dest, rw.
- Each rising edge: WB <= MEM, MEM <= EX.
- EX loads:
  - the ID fields when stall=0 and flush=0;
  - a bubble (v=0, rw=0, mr=0, all fields 0) when stall=1 or flush=1.
- Forward select encoding, fixed and shared with the forwarding mux:
  - 2'b00 = register-file value.
  - 2'b10 = EX/MEM result.
  - 2'b01 = MEM/WB result.
  - 2'b11 is never driven.
- forward_a, computed combinationally from shadow registers only, so it is glitch-free relative to EX:
  - 10 if MEM.v & MEM.rw & MEM.dest!=0 & MEM.dest==EX.rs;
  - else 01 if WB.v & WB.rw & WB.dest!=0 & WB.dest==EX.rs;
  - else 00.
  - MEM has priority when both stages match (most recent value wins).
- forward_b: identical rule using EX.rt.
- stall = id_valid & EX.v & EX.mr & EX.dest!=0 & (EX.dest==id_rs | (id_uses_rt & EX.dest==id_rt)).
  - Combinational, same cycle as the inputs.
- pc_write = ifid_write = ~stall.
- idex_bubble = stall | flush.
- stall and flush in the same cycle: flush wins for ID content (bubble inserted), but pc_write/ifid_write still follow stall.
- Stall lasts exactly one cycle per load-use pair. The next cycle the load is in MEM, EX holds a bubble, and the dependent instruction forwards from MEM/WB (01) one cycle later.
- stall_count:
  - increments on every rising edge with stall=1;
  - saturates at 2^CNT_W-1 and does not wrap;
  - cleared only by reset.
- Register $zero: never forwarded and never causes a stall.
- Reset, asynchronous and valid mid-operation:
  - all shadow valids/rw/mr = 0 and stall_count = 0;
  - forward_a = forward_b = 00, stall=0, pc_write=1, ifid_write=1, idex_bubble=flush.
  - In-flight hazards are discarded. The first post-reset instruction reads the register file.
- Latency: the hazard decision is 0 cycles after ID inputs. Forward selects apply to the instruction that entered EX on the previous edge.

Test Plan:
- Reset with rst_n=0 asserted mid-stream (hazard pending) -> forward_a=forward_b=00, stall=0, pc_write=1, stall_count=0 immediately, without waiting for a clock edge.
- Back-to-back ALU: add $3,$1,$2 then sub $4,$3,$5 -> when sub is in EX, forward_a=10, forward_b=00. One instruction apart -> forward_a=01.
- Double hazard: add $3 / add $3 / or $6,$3,$3 -> when `or` is in EX, forward_a=forward_b=10 (MEM priority over WB).
- Load-use: lw $2,0($1) then add $4,$2,$5 -> stall=1, pc_write=0, ifid_write=0, idex_bubble=1 for exactly one cycle, then forward_a=01 when add is in EX; stall_count=1.
- $zero and non-use: lw $0 followed by add using $0 -> no stall, forward 00. lw $7 followed by addi $8,$9,imm with id_rt=7, id_uses_rt=0 -> no stall.
- flush with a stall-causing ID instruction -> idex_bubble=1, EX.v=0 next cycle. Force stall for 65540 cycles -> stall_count holds at 16'hFFFF.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard control for a 5-stage MIPS pipeline.
// Shadows EX/MEM/WB destination info so forwarding depends only on pipeline state.
module fwd_hazard_unit #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dest;
        logic             rw;
        logic             mr;
    } ex_stage_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dest;
        logic             rw;
    } wr_stage_t;

    ex_stage_t ex_q;
    wr_stage_t mem_q;
    wr_stage_t wb_q;

    logic mem_fwd_ok;
    logic wb_fwd_ok;

    // A stage may forward only if it will really write a non-zero register.
    always_comb begin
        mem_fwd_ok = mem_q.v && mem_q.rw && (mem_q.dest != '0);
        wb_fwd_ok  = wb_q.v && wb_q.rw && (wb_q.dest != '0);
    end

    // MEM wins over WB so the most recent producer is selected.
    always_comb begin
        forward_a = FWD_RF;
        forward_b = FWD_RF;
        if (mem_fwd_ok && (mem_q.dest == ex_q.rs)) begin
            forward_a = FWD_MEM;
        end else if (wb_fwd_ok && (wb_q.dest == ex_q.rs)) begin
            forward_a = FWD_WB;
        end
        if (mem_fwd_ok && (mem_q.dest == ex_q.rt)) begin
            forward_b = FWD_MEM;
        end else if (wb_fwd_ok && (wb_q.dest == ex_q.rt)) begin
            forward_b = FWD_WB;
        end
    end

    // Load in EX whose result the ID instruction needs: hold PC/IF-ID, bubble ID/EX.
    always_comb begin
        stall = id_valid && ex_q.v && ex_q.mr && (ex_q.dest != '0) &&
                ((ex_q.dest == id_rs) || (id_uses_rt && (ex_q.dest == id_rt)));
        pc_write    = !stall;
        ifid_write  = !stall;
        idex_bubble = stall || flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= '{v: ex_q.v, dest: ex_q.dest, rw: ex_q.rw};
            if (idex_bubble) begin
                ex_q <= '0;
            end else begin
                ex_q <= '{v: id_valid, rs: id_rs, rt: id_rt, dest: id_dest,
                          rw: id_reg_write, mr: id_mem_read};
            end
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: instruction-history model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_fwd_hazard_unit;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned S_CNT_W = 3;
    localparam int          MAXCNT  = 65535;
    localparam int          S_MAX   = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [REG_W-1:0] id_rs, id_rt, id_dest;
    logic             id_uses_rt, id_reg_write, id_mem_read, flush;

    logic [1:0]         forward_a, forward_b;
    logic               stall, pc_write, ifid_write, idex_bubble;
    logic [CNT_W-1:0]   stall_count;
    logic [1:0]         s_forward_a, s_forward_b;
    logic               s_stall, s_pc_write, s_ifid_write, s_idex_bubble;
    logic [S_CNT_W-1:0] s_stall_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .forward_a(forward_a),
        .forward_b(forward_b), .stall(stall), .pc_write(pc_write),
        .ifid_write(ifid_write), .idex_bubble(idex_bubble), .stall_count(stall_count)
    );

    fwd_hazard_unit #(.REG_W(REG_W), .CNT_W(S_CNT_W)) dut_small (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .forward_a(s_forward_a),
        .forward_b(s_forward_b), .stall(s_stall), .pc_write(s_pc_write),
        .ifid_write(s_ifid_write), .idex_bubble(s_idex_bubble), .stall_count(s_stall_count)
    );

    // Model: hist[0] is the instruction in EX, hist[1] in MEM, hist[2] in WB.
    typedef struct {
        bit v;
        int rs;
        int rt;
        int dest;
        bit rw;
        bit mr;
    } ins_t;

    ins_t hist[3];
    int   m_cnt;
    int   m_scnt;

    function automatic bit m_stall();
        int d;
        d = hist[0].dest;
        return id_valid && hist[0].v && hist[0].mr && d != 0 &&
               (d == int'(id_rs) || (id_uses_rt && d == int'(id_rt)));
    endfunction

    function automatic logic [1:0] m_fwd(input int src);
        if (src == 0) return 2'b00;
        for (int k = 1; k <= 2; k++) begin
            if (hist[k].v && hist[k].rw && hist[k].dest == src)
                return (k == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) hist[k] = '{default: 0};
            m_cnt  = 0;
            m_scnt = 0;
        end else begin
            ins_t nxt;
            bit   s;
            s = m_stall();
            if (s) begin
                if (m_cnt < MAXCNT) m_cnt++;
                if (m_scnt < S_MAX) m_scnt++;
            end
            if (s || flush) nxt = '{default: 0};
            else nxt = '{v: id_valid, rs: int'(id_rs), rt: int'(id_rt),
                         dest: int'(id_dest), rw: id_reg_write, mr: id_mem_read};
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = nxt;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, mid-cycle away from the edge.
    always @(negedge clk) begin
        bit s;
        s = m_stall();
        chk("fwd_a", 32'(forward_a), 32'(m_fwd(hist[0].rs)));
        chk("fwd_b", 32'(forward_b), 32'(m_fwd(hist[0].rt)));
        chk("stall", 32'(stall), 32'(s));
        chk("pc_write", 32'(pc_write), 32'(!s));
        chk("ifid_write", 32'(ifid_write), 32'(!s));
        chk("idex_bubble", 32'(idex_bubble), 32'(s || flush));
        chk("stall_count", 32'(stall_count), 32'(m_cnt));
        chk("s_fwd_a", 32'(s_forward_a), 32'(m_fwd(hist[0].rs)));
        chk("s_fwd_b", 32'(s_forward_b), 32'(m_fwd(hist[0].rt)));
        chk("s_stall", 32'(s_stall), 32'(s));
        chk("s_ctrl", 32'({s_pc_write, s_ifid_write, s_idex_bubble}),
            32'({!s, !s, s || flush}));
        chk("s_stall_count", 32'(s_stall_count), 32'(m_scnt));
    end

    task automatic drv(input int v, input int rs, input int rt, input int ur,
                       input int dest, input int rw, input int mr, input int fl);
        id_valid     = v[0];
        id_rs        = REG_W'(rs);
        id_rt        = REG_W'(rt);
        id_uses_rt   = ur[0];
        id_dest      = REG_W'(dest);
        id_reg_write = rw[0];
        id_mem_read  = mr[0];
        flush        = fl[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string n, input logic [1:0] fa, input logic [1:0] fb,
                       input logic st, input int cnt);
        #1;
        chk({n, ".fa"}, 32'(forward_a), 32'(fa));
        chk({n, ".fb"}, 32'(forward_b), 32'(fb));
        chk({n, ".stall"}, 32'(stall), 32'(st));
        chk({n, ".cnt"}, 32'(stall_count), 32'(cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        lit("reset", 2'b00, 2'b00, 1'b0, 0);
        chk("reset.pc_write", 32'(pc_write), 32'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // add $3,$1,$2 ; sub $4,$3,$5 ; or $9,$10,$3
        drv(1, 1, 2, 1, 3, 1, 0, 0); tick();
        drv(1, 3, 5, 1, 4, 1, 0, 0); tick();
        lit("b2b", 2'b10, 2'b00, 1'b0, 0);
        drv(1, 10, 3, 1, 9, 1, 0, 0); tick();
        lit("one_apart", 2'b00, 2'b01, 1'b0, 0);

        // add $3 ; add $3 ; or $6,$3,$3
        drv(1, 1, 1, 1, 3, 1, 0, 0); tick();
        drv(1, 2, 2, 1, 3, 1, 0, 0); tick();
        drv(1, 3, 3, 1, 6, 1, 0, 0); tick();
        lit("double", 2'b10, 2'b10, 1'b0, 0);

        // lw $2,0($1) ; add $4,$2,$5
        drv(1, 1, 2, 0, 2, 1, 1, 0); tick();
        drv(1, 2, 5, 1, 4, 1, 0, 0);
        lit("lu_stall", 2'b00, 2'b00, 1'b1, 0);
        chk("lu_stall.ctrl", 32'({pc_write, ifid_write, idex_bubble}), 32'(3'b001));
        tick();
        lit("lu_bubble", 2'b00, 2'b00, 1'b0, 1);
        chk("lu_bubble.ctrl", 32'({pc_write, ifid_write, idex_bubble}), 32'(3'b110));
        tick();
        lit("lu_fwd", 2'b01, 2'b00, 1'b0, 1);

        // lw $0 ; add $4,$0,$0
        drv(1, 1, 0, 0, 0, 1, 1, 0); tick();
        drv(1, 0, 0, 1, 4, 1, 0, 0);
        lit("zero_nostall", 2'b00, 2'b00, 1'b0, 1);
        tick();
        lit("zero_fwd", 2'b00, 2'b00, 1'b0, 1);

        // lw $7 ; addi $8,$9,imm with rt=7 not read
        drv(1, 1, 7, 0, 7, 1, 1, 0); tick();
        drv(1, 9, 7, 0, 8, 1, 0, 0);
        lit("nonuse", 2'b00, 2'b00, 1'b0, 1);
        tick();

        // Load-use coinciding with flush
        drv(1, 1, 2, 0, 2, 1, 1, 0); tick();
        drv(1, 2, 2, 1, 4, 1, 0, 1);
        #1;
        chk("flush.ctrl", 32'({stall, pc_write, ifid_write, idex_bubble}), 32'(4'b1001));
        tick();
        drv(1, 2, 2, 1, 4, 1, 0, 0);
        lit("flush_after", 2'b00, 2'b00, 1'b0, 2);
        tick();

        // Mid-stream reset with a forward and a stall pending
        drv(1, 1, 1, 1, 5, 1, 0, 0); tick();
        drv(1, 5, 0, 0, 6, 1, 1, 0); tick();
        drv(1, 6, 6, 1, 7, 1, 0, 0);
        lit("pre_rst", 2'b10, 2'b00, 1'b1, 2);
        rst_n = 1'b0;
        lit("in_rst", 2'b00, 2'b00, 1'b0, 0);
        chk("in_rst.ctrl", 32'({pc_write, ifid_write, idex_bubble}), 32'(3'b110));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        lit("post_rst", 2'b00, 2'b00, 1'b0, 0);

        // Repeated load-use pairs drive the narrow counter into saturation
        for (int i = 0; i < 10; i++) begin
            drv(1, 1, 2, 0, 2, 1, 1, 0); tick();
            drv(1, 2, 3, 1, 4, 1, 0, 0); tick();
            tick();
        end
        lit("sat", 2'b01, 2'b00, 1'b0, 10);
        chk("sat.small", 32'(s_stall_count), 32'(S_MAX));

        drv(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
